divisor_sequencial_4bits: RTL and testbench

Multi-cycle unsigned restoring divider for the ULA datapath: computes `quociente = dividendo / divisor` and `resto = dividendo % divisor`, one quotient bit per clock. It is the inverse operation to the combinational adder/subtractor and performs each trial subtraction with the same borrow rule. It is driven by the ULA control through a start/busy/done handshake. It reports division by zero instead of producing an undefined result.

---
 rtl/divisor_sequencial_4bits.sv | 133 +++++++++++++
 tb/tb_divisor_sequencial_4bits.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_sequencial_4bits.sv
// divisor_sequencial_4bits
//
// Multi-cycle unsigned restoring divider for the ULA datapath. Each clock
// produces one quotient bit: quociente = dividendo / divisor and
// resto = dividendo % divisor. A zero divisor is reported through erro_div0
// instead of producing an undefined result.
//
// Ports:
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   iniciar    : start request, sampled only while ocupado = 0
//   dividendo  : dividend, captured on the accepting edge
//   divisor    : divisor, captured on the accepting edge
//   ocupado    : high while the FSM is not idle
//   pronto     : one-cycle pulse marking a complete result
//   quociente  : quotient, held until the next completion
//   resto      : remainder, held until the next completion
//   erro_div0  : set on completion when the divisor was zero
module divisor_sequencial_4bits #(
    parameter int LARGURA = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               iniciar,
    input  logic [LARGURA-1:0] dividendo,
    input  logic [LARGURA-1:0] divisor,
    output logic               ocupado,
    output logic               pronto,
    output logic [LARGURA-1:0] quociente,
    output logic [LARGURA-1:0] resto,
    output logic               erro_div0
);

    localparam int CW = $clog2(LARGURA + 1);

    typedef enum logic [1:0] {
        OCIOSO,
        CALCULA,
        FIM
    } estado_t;

    estado_t            estado;
    logic [LARGURA:0]   r;
    logic [LARGURA-1:0] q;
    logic [CW-1:0]      cont;
    logic [LARGURA-1:0] div_r;

    logic [LARGURA:0]   r_desl;
    logic [LARGURA:0]   t;
    logic [LARGURA:0]   r_prox;
    logic [LARGURA-1:0] q_prox;

    // Trial subtraction at LARGURA+1 bits; the MSB of the result is the borrow.
    function automatic logic [LARGURA:0] subtrai(input logic [LARGURA:0]   a,
                                                 input logic [LARGURA-1:0] d);
        return a - {1'b0, d};
    endfunction

    // One restoring iteration. The partial remainder is always below the
    // divisor, so dropping R's MSB during the shift never loses information.
    always_comb begin
        r_desl = (r << 1) | {{LARGURA{1'b0}}, q[LARGURA-1]};
        t      = subtrai(r_desl, div_r);
        if (!t[LARGURA]) begin
            r_prox = t;
            q_prox = {q[LARGURA-2:0], 1'b1};
        end else begin
            r_prox = r_desl;
            q_prox = {q[LARGURA-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado    <= OCIOSO;
            ocupado   <= 1'b0;
            pronto    <= 1'b0;
            quociente <= '0;
            resto     <= '0;
            erro_div0 <= 1'b0;
            r         <= '0;
            q         <= '0;
            cont      <= '0;
            div_r     <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    pronto <= 1'b0;
                    if (iniciar) begin
                        div_r   <= divisor;
                        ocupado <= 1'b1;
                        if (divisor != '0) begin
                            r      <= '0;
                            q      <= dividendo;
                            cont   <= CW'(LARGURA);
                            estado <= CALCULA;
                        end else begin
                            // Divide by zero skips the iterations entirely.
                            quociente <= '1;
                            resto     <= dividendo;
                            erro_div0 <= 1'b1;
                            pronto    <= 1'b1;
                            estado    <= FIM;
                        end
                    end
                end
                CALCULA: begin
                    r    <= r_prox;
                    q    <= q_prox;
                    cont <= cont - CW'(1);
                    if (cont == CW'(1)) begin
                        quociente <= q_prox;
                        resto     <= r_prox[LARGURA-1:0];
                        erro_div0 <= 1'b0;
                        pronto    <= 1'b1;
                        estado    <= FIM;
                    end
                end
                FIM: begin
                    pronto  <= 1'b0;
                    ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end
                default: begin
                    pronto  <= 1'b0;
                    ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_sequencial_4bits.sv
// tb_divisor_sequencial_4bits
//
// Directed bench for divisor_sequencial_4bits at LARGURA = 4: reset state,
// directed divisions, divide by zero, busy/hold behaviour, mid-operation
// reset and an exhaustive back-to-back sweep against a reference model.
module tb_divisor_sequencial_4bits;

    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         iniciar;
    logic [L-1:0] dividendo;
    logic [L-1:0] divisor;
    logic         ocupado;
    logic         pronto;
    logic [L-1:0] quociente;
    logic [L-1:0] resto;
    logic         erro_div0;

    int n_checks = 0;
    int n_fail   = 0;

    // Results the bench expects the DUT to be holding right now.
    logic [L-1:0] exp_q = '0;
    logic [L-1:0] exp_r = '0;
    logic         exp_e = 1'b0;

    divisor_sequencial_4bits #(.LARGURA(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iniciar   (iniciar),
        .dividendo (dividendo),
        .divisor   (divisor),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .quociente (quociente),
        .resto     (resto),
        .erro_div0 (erro_div0)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Starts one division from a negedge and follows it until ocupado drops.
    // n counts edges after the accepting edge. Before pronto the outputs must
    // equal the previously expected results; after pronto they must hold.
    task automatic run_div(input logic [L-1:0] a, input logic [L-1:0] b, input bit hold,
                           output logic [L-1:0] q, output logic [L-1:0] r, output logic e,
                           output int lat, output int busy, output int pulses,
                           output bit held_ok);
        int n;
        bit got;
        lat = -1; busy = 0; pulses = 0; held_ok = 1'b1; got = 1'b0;
        q = 'x; r = 'x; e = 1'bx;
        iniciar   = 1'b1;
        dividendo = a;
        divisor   = b;
        @(posedge clk);
        n = 0;
        forever begin
            @(negedge clk);
            if (hold) begin
                dividendo = L'($urandom);
                divisor   = L'($urandom);
            end else begin
                iniciar = 1'b0;
            end
            if (pronto) begin
                pulses++;
                if (!got) begin
                    lat = n; q = quociente; r = resto; e = erro_div0; got = 1'b1;
                end
            end else if (got) begin
                if (quociente !== q || resto !== r || erro_div0 !== e) held_ok = 1'b0;
            end else begin
                if (quociente !== exp_q || resto !== exp_r || erro_div0 !== exp_e) held_ok = 1'b0;
            end
            if (ocupado) busy++;
            else break;
            n++;
            if (n > 20) break;
        end
        iniciar = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; iniciar = 1'b0; dividendo = '0; divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({ocupado, pronto, erro_div0} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: ocupado/pronto/erro=%b required 000", {ocupado, pronto, erro_div0});
        end
        n_checks++;
        if ({quociente, resto} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: q=%0d r=%0d required 0 0", quociente, resto);
        end
        rst_n = 1'b1;
        exp_q = '0; exp_r = '0; exp_e = 1'b0;
    endtask

    task automatic test_basic();
        logic [L-1:0] ta [4] = '{4'd13, 4'd15, 4'd3, 4'd9};
        logic [L-1:0] tb [4] = '{4'd4,  4'd1,  4'd9, 4'd9};
        logic [L-1:0] tq [4] = '{4'd3,  4'd15, 4'd0, 4'd1};
        logic [L-1:0] tr [4] = '{4'd1,  4'd0,  4'd3, 4'd0};
        logic [L-1:0] q, r;
        logic e;
        int lat, busy, pulses;
        bit held;
        for (int i = 0; i < 4; i++) begin
            run_div(ta[i], tb[i], 1'b0, q, r, e, lat, busy, pulses, held);
            n_checks++;
            if ({q, r, e} !== {tq[i], tr[i], 1'b0}) begin
                n_fail++;
                $display("FAIL basic_result %0d/%0d: q=%0d r=%0d e=%b required %0d %0d 0",
                         ta[i], tb[i], q, r, e, tq[i], tr[i]);
            end
            n_checks++;
            if (lat !== L || busy !== L + 1 || pulses !== 1) begin
                n_fail++;
                $display("FAIL basic_timing %0d/%0d: lat=%0d busy=%0d pulses=%0d required %0d %0d 1",
                         ta[i], tb[i], lat, busy, pulses, L, L + 1);
            end
            n_checks++;
            if (!held) begin
                n_fail++;
                $display("FAIL basic_hold %0d/%0d: outputs moved outside completion edge, required stable",
                         ta[i], tb[i]);
            end
            exp_q = tq[i]; exp_r = tr[i]; exp_e = 1'b0;
        end
    endtask

    task automatic test_div0();
        logic [L-1:0] q, r;
        logic e;
        int lat, busy, pulses;
        bit held;
        run_div(4'd7, 4'd0, 1'b0, q, r, e, lat, busy, pulses, held);
        n_checks++;
        if ({q, r, e} !== {4'd15, 4'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL div0_result: q=%0d r=%0d e=%b required 15 7 1", q, r, e);
        end
        n_checks++;
        if (lat !== 0 || busy !== 1 || pulses !== 1 || !held) begin
            n_fail++;
            $display("FAIL div0_timing: lat=%0d busy=%0d pulses=%0d held=%b required 0 1 1 1",
                     lat, busy, pulses, held);
        end
        exp_q = 4'd15; exp_r = 4'd7; exp_e = 1'b1;
        run_div(4'd8, 4'd2, 1'b0, q, r, e, lat, busy, pulses, held);
        n_checks++;
        if ({q, r, e} !== {4'd4, 4'd0, 1'b0} || !held) begin
            n_fail++;
            $display("FAIL div0_recover: q=%0d r=%0d e=%b held=%b required 4 0 0 1", q, r, e, held);
        end
        exp_q = 4'd4; exp_r = 4'd0; exp_e = 1'b0;
    endtask

    task automatic test_busy_hold();
        logic [L-1:0] q, r;
        logic e;
        int lat, busy, pulses;
        bit held;
        run_div(4'd13, 4'd4, 1'b1, q, r, e, lat, busy, pulses, held);
        n_checks++;
        if ({q, r, e} !== {4'd3, 4'd1, 1'b0} || pulses !== 1 || lat !== L) begin
            n_fail++;
            $display("FAIL hold_start: q=%0d r=%0d e=%b pulses=%0d lat=%0d required 3 1 0 1 %0d",
                     q, r, e, pulses, lat, L);
        end
        exp_q = 4'd3; exp_r = 4'd1; exp_e = 1'b0;
        // The next run must keep showing 3 rem 1 until its own completion.
        run_div(4'd11, 4'd5, 1'b0, q, r, e, lat, busy, pulses, held);
        n_checks++;
        if (!held || {q, r, e} !== {4'd2, 4'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_results: held=%b q=%0d r=%0d required 1 2 1", held, q, r);
        end
        exp_q = 4'd2; exp_r = 4'd1; exp_e = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [L-1:0] q, r;
        logic e;
        int lat, busy, pulses;
        bit held;
        int seen;
        run_div(4'd13, 4'd4, 1'b0, q, r, e, lat, busy, pulses, held);
        exp_q = 4'd3; exp_r = 4'd1; exp_e = 1'b0;
        iniciar = 1'b1; dividendo = 4'd14; divisor = 4'd3;
        @(posedge clk);
        @(negedge clk);
        iniciar = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ocupado, pronto, erro_div0} !== 3'b000 || {quociente, resto} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_async: ocupado=%b pronto=%b q=%0d r=%0d e=%b required all 0",
                     ocupado, pronto, quociente, resto, erro_div0);
        end
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (pronto) seen++;
        end
        rst_n = 1'b1;
        exp_q = '0; exp_r = '0; exp_e = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (pronto) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_pronto: pronto seen %0d times required 0", seen);
        end
        run_div(4'd14, 4'd3, 1'b0, q, r, e, lat, busy, pulses, held);
        n_checks++;
        if ({q, r, e} !== {4'd4, 4'd2, 1'b0} || !held || lat !== L) begin
            n_fail++;
            $display("FAIL reset_mid_after: q=%0d r=%0d e=%b held=%b lat=%0d required 4 2 0 1 %0d",
                     q, r, e, held, lat, L);
        end
        exp_q = 4'd4; exp_r = 4'd2; exp_e = 1'b0;
    endtask

    // Every pair, started as early as the handshake allows. A normal run
    // occupies L+2 cycles start to start, a divide-by-zero run 2.
    task automatic test_back_to_back();
        logic [L-1:0] q, r, mq, mr;
        logic e, me;
        int lat, busy, pulses, mlat;
        bit held;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    mq = 4'd15; mr = L'(a); me = 1'b1; mlat = 0;
                end else begin
                    mq = L'(a / b); mr = L'(a % b); me = 1'b0; mlat = L;
                end
                run_div(L'(a), L'(b), 1'b0, q, r, e, lat, busy, pulses, held);
                n_checks++;
                if ({q, r, e} !== {mq, mr, me}) begin
                    n_fail++;
                    $display("FAIL sweep_result %0d/%0d: q=%0d r=%0d e=%b required %0d %0d %b",
                             a, b, q, r, e, mq, mr, me);
                end
                n_checks++;
                if (lat !== mlat || busy !== mlat + 1 || pulses !== 1 || !held) begin
                    n_fail++;
                    $display("FAIL sweep_timing %0d/%0d: lat=%0d busy=%0d pulses=%0d held=%b required %0d %0d 1 1",
                             a, b, lat, busy, pulses, held, mlat, mlat + 1);
                end
                exp_q = mq; exp_r = mr; exp_e = me;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div0();
        test_busy_hold();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
